ifetch_prefetch_unit: RTL

// - Parametrised instruction-fetch front end; successor to the single-request IF/IW fetch of custom_cpu.
// - Keeps up to DEPTH requests in flight on the instruction request/response channels.
// - Queues returned words with their PC in a FIFO, so the core pops one instruction per cycle.
// - Supports redirect (branch/jump): flushes queued words and discards stale in-flight responses.

---
 rtl/ifetch_prefetch_unit_pkg.sv | 21 ++
 rtl/ifetch_prefetch_unit_sync_fifo.sv | 57 +++++
 rtl/ifetch_prefetch_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_prefetch_unit_pkg.sv
// Shared fetch-side definitions: default widths, NOP encoding, PC step,
// request FSM encoding and counter-width helper.
package ifetch_prefetch_unit_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned INST_W_DEF = 32;
    localparam int unsigned PC_STEP    = 4;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_REQ        = 2'd1,
        ST_REDIR_WAIT = 2'd2
    } req_state_e;

    // Width of a counter that must hold 0..depth inclusive
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifetch_prefetch_unit_sync_fifo.sv
// Synchronous FIFO with push/pop/flush and exact full/empty/count.
// DEPTH must be a power of two so pointers wrap naturally.
module ifetch_prefetch_unit_sync_fifo
    import ifetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic                      i_flush,
    input  logic [WIDTH-1:0]          i_din,
    output logic [WIDTH-1:0]          o_dout,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [cnt_w(DEPTH)-1:0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    // Pointer and occupancy tracking; flush empties the queue
    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage array, contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/ifetch_prefetch_unit.sv
// Instruction-fetch prefetch front end: keeps up to DEPTH requests in flight,
// queues returned words with their PC, and handles redirects by flushing the
// queue and discarding stale in-flight responses.
// Optional feature macro: IFETCH_PERF_CNT_EN adds fetch/drop/stall counters.
module ifetch_prefetch_unit
    import ifetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       INST_W   = INST_W_DEF,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] PC,
    output logic              Inst_Req_Valid,
    input  logic              Inst_Req_Ready,
    input  logic [INST_W-1:0] Instruction,
    input  logic              Inst_Valid,
    output logic              Inst_Ready,
    output logic              fetch_valid,
    output logic [INST_W-1:0] fetch_inst,
    output logic [ADDR_W-1:0] fetch_pc,
    input  logic              fetch_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_drop_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int unsigned CW = cnt_w(DEPTH);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned FW = ADDR_W + INST_W;

    req_state_e        r_state;
    req_state_e        w_state_n;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_n;
    logic [ADDR_W-1:0] r_pend_pc;
    logic [ADDR_W-1:0] w_pend_pc_n;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [CW-1:0]     r_outst;
    logic [CW-1:0]     w_outst_n;
    logic [CW-1:0]     r_drop;
    logic [CW-1:0]     w_drop_n;
    logic [CW-1:0]     w_occ;
    logic [CW-1:0]     w_occ_n;
    logic              r_resp_ready;
    logic              w_req_valid;
    logic              w_accept;
    logic              w_resp;
    logic              w_drop_hit;
    logic              w_push;
    logic              w_pop;
    logic              w_pending;
    logic              w_credit_n;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [FW-1:0]     w_fifo_dout;

    // Handshake qualifiers for this cycle
    always_comb begin
        w_accept   = w_req_valid && Inst_Req_Ready;
        w_pending  = w_req_valid && !Inst_Req_Ready;
        w_resp     = Inst_Valid && r_resp_ready && (r_outst != '0);
        w_drop_hit = w_resp && (r_drop != '0);
        w_push     = w_resp && !w_drop_hit && !redirect_valid && !w_fifo_full;
        w_pop      = !w_fifo_empty && fetch_ready && !redirect_valid;
    end

    // Next values of the in-flight, stale and occupancy counters, and credit
    always_comb begin
        w_outst_n = r_outst + CW'(w_accept) - CW'(w_resp);
        w_drop_n  = r_drop - CW'(w_drop_hit);
        w_occ_n   = w_occ + CW'(w_push) - CW'(w_pop);
        if (redirect_valid) begin
            // Every response still owed belongs to the old stream
            w_drop_n = w_outst_n + CW'(w_pending);
            w_occ_n  = '0;
        end
        w_credit_n = (SW'(w_occ_n) + SW'(w_outst_n)) < SW'(DEPTH);
    end

    // Request FSM state register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_n;
    end

    // Request FSM next state, next PC and pending redirect target
    always_comb begin
        w_state_n   = r_state;
        w_pc_n      = r_pc;
        w_pend_pc_n = r_pend_pc;
        case (r_state)
            ST_IDLE, ST_REQ: begin
                if (w_pending) begin
                    // Held request may not be withdrawn; remember the target
                    if (redirect_valid) begin
                        w_pend_pc_n = redirect_pc;
                        w_state_n   = ST_REDIR_WAIT;
                    end
                end else begin
                    if (redirect_valid) w_pc_n = redirect_pc;
                    else if (w_accept)  w_pc_n = r_pc + ADDR_W'(PC_STEP);
                    w_state_n = w_credit_n ? ST_REQ : ST_IDLE;
                end
            end
            ST_REDIR_WAIT: begin
                if (redirect_valid) w_pend_pc_n = redirect_pc;
                if (w_accept) begin
                    w_pc_n    = redirect_valid ? redirect_pc : r_pend_pc;
                    w_state_n = w_credit_n ? ST_REQ : ST_IDLE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Request FSM outputs
    always_comb begin
        w_req_valid    = (r_state != ST_IDLE);
        Inst_Req_Valid = w_req_valid;
        PC             = r_pc;
    end

    // Fetch datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc         <= RESET_PC;
            r_pend_pc    <= '0;
            r_resp_pc    <= RESET_PC;
            r_outst      <= '0;
            r_drop       <= '0;
            r_resp_ready <= 1'b0;
        end else begin
            r_pc         <= w_pc_n;
            r_pend_pc    <= w_pend_pc_n;
            r_outst      <= w_outst_n;
            r_drop       <= w_drop_n;
            r_resp_ready <= 1'b1;
            if (redirect_valid) r_resp_pc <= redirect_pc;
            else if (w_push)    r_resp_pc <= r_resp_pc + ADDR_W'(PC_STEP);
        end
    end

    ifetch_prefetch_unit_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_din   ({r_resp_pc, Instruction}),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_occ)
    );

    assign Inst_Ready  = r_resp_ready;
    assign fetch_valid = !w_fifo_empty;
    assign fetch_pc    = w_fifo_dout[FW-1 -: ADDR_W];
    assign fetch_inst  = w_fifo_empty ? INST_W'(NOP_INST) : w_fifo_dout[INST_W-1:0];

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_drop;
    logic [31:0] r_perf_stall;

    // Free-running event counters, wrap on overflow
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_fetch <= '0;
            r_perf_drop  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_push)                                    r_perf_fetch <= r_perf_fetch + 32'd1;
            if (w_resp && (w_drop_hit || redirect_valid))  r_perf_drop  <= r_perf_drop + 32'd1;
            if (w_pending)                                 r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_drop_cnt  = r_perf_drop;
    assign perf_stall_cnt = r_perf_stall;
`endif

`ifndef SYNTHESIS
    // Responses must only arrive against an outstanding request
    always @(posedge clk) begin
        if (rst && Inst_Valid && r_resp_ready) begin
            assert (r_outst != '0)
                else $error("protocol violation: response with no outstanding request");
        end
    end
`endif

endmodule
